// File: rtl/mem_subword_ctrl.sv
// Sub-word load/store sequencer in front of a word-only data memory.
// Byte/halfword stores are done as a read-modify-write of the containing word.
module mem_subword_ctrl #(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid_in,
    output logic        req_ready_out,
    input  logic        req_we_in,
    input  logic [31:0] req_addr_in,
    input  logic [1:0]  req_size_in,
    input  logic        req_signed_in,
    input  logic [31:0] req_wdata_in,
    output logic        resp_valid_out,
    output logic [31:0] resp_rdata_out,
    output logic        resp_err_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_writedata_out,
    output logic        mem_re_out,
    output logic        mem_we_out,
    output logic [1:0]  mem_size_out,
    input  logic [31:0] mem_readdata_in
);

    // state  | meaning
    // IDLE   | ready for a new request
    // ACCESS | word write, or read of the containing word
    // WRITE  | write back the merged word of a sub-word store
    // DONE   | one-cycle response pulse
    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_ILL  = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] result_q, result_d;
    logic [31:0] merged_q, merged_d;

    logic        accept;
    logic        accept_err;
    logic [4:0]  lane_sh;
    logic [15:0] lane_data;
    logic [31:0] lane_mask;
    logic [31:0] load_ext;
    logic [31:0] merge_word;

    assign req_ready_out     = (state_q == IDLE) && !reset;
    assign accept            = req_valid_in && req_ready_out;
    assign accept_err        = (req_size_in == SZ_ILL) ||
                               ((req_size_in == SZ_HALF) && req_addr_in[0]) ||
                               ((req_size_in == SZ_WORD) && (req_addr_in[1:0] != 2'b00));

    assign mem_size_out      = SZ_WORD;
    assign mem_addr_out      = {addr_q[31:2], 2'b00};
    assign mem_writedata_out = (state_q == WRITE) ? merged_q : wdata_q;
    assign resp_valid_out    = (state_q == DONE);
    assign resp_err_out      = (state_q == DONE) && err_q;
    assign resp_rdata_out    = result_q;

    // Shift that brings the addressed lane down to bit 0.
    always_comb begin
        lane_sh = 5'd0;
        if (size_q == SZ_BYTE) begin
            lane_sh = BIG_ENDIAN ? {~addr_q[1:0], 3'b000} : {addr_q[1:0], 3'b000};
        end else begin
            lane_sh = BIG_ENDIAN ? {~addr_q[1], 4'b0000} : {addr_q[1], 4'b0000};
        end
    end

    assign lane_data  = 16'(mem_readdata_in >> lane_sh);
    assign lane_mask  = ((size_q == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF) << lane_sh;
    assign merge_word = (mem_readdata_in & ~lane_mask) | ((wdata_q << lane_sh) & lane_mask);

    always_comb begin
        load_ext = mem_readdata_in;
        case (size_q)
            SZ_BYTE: load_ext = signed_q ? {{24{lane_data[7]}}, lane_data[7:0]}
                                         : {24'd0, lane_data[7:0]};
            SZ_HALF: load_ext = signed_q ? {{16{lane_data[15]}}, lane_data}
                                         : {16'd0, lane_data};
            default: load_ext = mem_readdata_in;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        size_d     = size_q;
        signed_d   = signed_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        result_d   = result_q;
        merged_d   = merged_q;
        mem_re_out = 1'b0;
        mem_we_out = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d     = req_we_in;
                    addr_d   = req_addr_in;
                    size_d   = req_size_in;
                    signed_d = req_signed_in;
                    wdata_d  = req_wdata_in;
                    err_d    = accept_err;
                    if (accept_err) begin
                        result_d = 32'd0;
                        state_d  = DONE;
                    end else begin
                        state_d  = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (we_q && (size_q == SZ_WORD)) begin
                    mem_we_out = 1'b1;
                    result_d   = 32'd0;
                    state_d    = DONE;
                end else if (!we_q) begin
                    mem_re_out = 1'b1;
                    result_d   = load_ext;
                    state_d    = DONE;
                end else begin
                    mem_re_out = 1'b1;
                    merged_d   = merge_word;
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                mem_we_out = 1'b1;
                result_d   = 32'd0;
                state_d    = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            addr_q   <= 32'd0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            wdata_q  <= 32'd0;
            err_q    <= 1'b0;
            result_q <= 32'd0;
            merged_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
            result_q <= result_d;
            merged_q <= merged_d;
        end
    end

endmodule

// File: doc/mem_subword_ctrl.md
Name: mem_subword_ctrl

Overview:
- Sequencer between the pipeline MEM stage and data_memory. data_memory only supports 4-byte word accesses.
- Implements byte/halfword loads (with sign/zero extension) and byte/halfword stores (via word read-modify-write), plus plain word accesses.
- Presents a valid/ready request port and a one-cycle response pulse to the pipeline, which stalls while req_ready_out is low.
- Drives data_memory's addr/writedata/re/we/size inputs; samples its readdata.

Parameters:
- BIG_ENDIAN, 1, byte lane order; 1 = MIPS big-endian (byte offset 0 is bits [31:24]); 0 = little-endian (offset 0 is bits [7:0]).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid_in  in  1  request present
- req_ready_out  out  1  controller can accept a request this cycle
- req_we_in  in  1  1 = store, 0 = load
- req_addr_in  in  32  byte address
- req_size_in  in  2  00 byte, 01 halfword, 11 word, 10 illegal
- req_signed_in  in  1  load sign-extends when 1
- req_wdata_in  in  32  store data, right-justified
- resp_valid_out  out  1  one-cycle completion pulse
- resp_rdata_out  out  32  load result, extended; 0 for stores and errors
- resp_err_out  out  1  misaligned or illegal-size request; qualified by resp_valid_out
- mem_addr_out  out  32  word-aligned address to data_memory
- mem_writedata_out  out  32  write word to data_memory
- mem_re_out  out  1  read enable
- mem_we_out  out  1  write enable; data_memory commits on the clock edge while high
- mem_size_out  out  2  constant 2'b11
- mem_readdata_in  in  32  data_memory read data, combinational from mem_addr_out

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high; ports are named clock and reset.
- Reset values: state=IDLE, resp_valid_out=0, resp_rdata_out=0, resp_err_out=0, mem_re_out=0, mem_we_out=0, mem_addr_out=0, mem_writedata_out=0.
- req_ready_out = (state==IDLE) && !reset.
- Accept: an edge with req_valid_in && req_ready_out latches we, addr, size, signed and wdata into internal registers. Request inputs are ignored in all other states.
- Error check at accept:
  - Error conditions: size 10; size 01 with addr[0]=1; size 11 with addr[1:0]!=0.
  - On error: go to DONE with err set; mem_re_out and mem_we_out stay 0 for the entire request.
- States:
  - IDLE -> ACCESS on accept (no error); IDLE -> DONE on accept with error.
  - ACCESS: mem_addr_out={addr[31:2],2'b00}.
    - Word store: mem_we_out=1, mem_writedata_out=wdata; next state DONE.
    - Otherwise: mem_re_out=1.
    - Load: extract the lane from mem_readdata_in, extend, latch into the result register; next state DONE.
    - Subword store: merge wdata[7:0] or wdata[15:0] into the selected lane of mem_readdata_in, latch the merged word; next state WRITE.
  - WRITE: same mem_addr_out, mem_we_out=1, mem_writedata_out=merged word, mem_re_out=0; next state DONE.
  - DONE: resp_valid_out=1 for exactly one cycle with resp_rdata_out and resp_err_out valid; next state IDLE.
- Lane selection (BIG_ENDIAN=1):
  - Byte offsets 0..3 map to bits [31:24], [23:16], [15:8], [7:0].
  - Halfword offset 0 maps to [31:16]; offset 2 maps to [15:0].
- Extension: signed loads replicate the MSB of the selected lane; unsigned loads zero-fill. Word loads pass through unchanged.
- Latency, counted from the accept edge, as resp_valid_out high during cycle N:
  - Load or word store: N=2.
  - Subword store: N=3.
  - Error: N=1.
- Throughput: next accept possible in the DONE cycle's following IDLE cycle; no request overlap; back-to-back requests are spaced by response completion.
- mem_addr_out and mem_writedata_out are don't-care when re and we are both 0, but must not change during ACCESS or WRITE.
- Reset mid-operation:
  - A write whose we is high in the cycle reset is sampled completes at that edge.
  - All other in-flight work is dropped with no response.
  - State returns to IDLE; req_ready_out=1 the first cycle after reset deasserts.
- resp_rdata_out holds its value after the pulse until the next DONE.

Test Plan:
- Memory word at 0x10000000 = 0x8899AABB; signed byte load @0x10000001 -> ACCESS shows mem_addr_out=0x10000000, re=1; resp_valid_out 2 cycles after accept with rdata=0xFFFFFF99, err=0.
- Unsigned halfword load @0x10000002 -> rdata=0x0000AABB; signed halfword load @0x10000000 -> 0xFFFF8899.
- Byte store @0x10000003, wdata=0x123456CC -> one re cycle, then one we cycle writing 0x8899AACC; resp at cycle 3; subsequent word load returns 0x8899AACC.
- Word load @0x10000006, then size 10 @0x10000000 -> each gives resp 1 cycle after accept, err=1, rdata=0; re/we never asserted.
- Halfword store accepted, reset asserted during ACCESS -> mem_we_out never asserted; no resp_valid_out; memory unchanged; ready=1 after reset drops.
- req_valid_in held high with two word loads queued -> second accepted in the IDLE cycle following the first DONE; responses exactly 3 cycles apart.
